// File: rtl/real_div.sv
// Iterative IEEE-754 divider (binary32 or binary64): radix-2 restoring mantissa divide,
// one quotient bit per cycle, round-to-nearest-even, subnormals flushed to zero.
module real_div #(
    parameter int unsigned IS_DOUBLE = 0
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] op1,
    input  logic [63:0] op2,
    output logic        busy,
    output logic        valid,
    output logic [63:0] result,
    output logic [3:0]  flags
);

    localparam int MW   = (IS_DOUBLE != 0) ? 53 : 24;
    localparam int EW   = (IS_DOUBLE != 0) ? 11 : 8;
    localparam int BIAS = (IS_DOUBLE != 0) ? 1023 : 127;
    localparam int W    = (IS_DOUBLE != 0) ? 64 : 32;
    localparam int FW   = MW - 1;
    localparam int Q    = MW + 2;
    localparam int CW   = $clog2(Q);
    localparam int XW   = EW + 2;

    localparam logic [EW-1:0] E_MAX      = {EW{1'b1}};
    localparam logic [FW-1:0] QNAN_FRAC  = {1'b1, {(FW - 1){1'b0}}};
    localparam logic [XW-1:0] EXP_INF    = XW'((1 << EW) - 1);
    localparam logic [XW-1:0] BIAS_V     = XW'(BIAS);

    typedef enum logic [2:0] {StIdle, StLoad, StDiv, StRnd, StDone} state_e;

    state_e        state_q;
    logic [W-1:0]  a_q, b_q;
    logic          sign_q;
    logic [XW-1:0] exp_q;
    logic [MW-1:0] div_q;
    logic [MW:0]   rem_q;
    logic [Q-1:0]  quo_q;
    logic [CW-1:0] cnt_q;
    logic [63:0]   res_q;
    logic [3:0]    flg_q;

    function automatic logic [63:0] pack(input logic s, input logic [EW-1:0] e,
                                         input logic [FW-1:0] f);
        logic [W-1:0] w;
        w = {s, e, f};
        return 64'(w);
    endfunction

    if (IS_DOUBLE == 0) begin : g_single
        logic unused_hi;
        assign unused_hi = ^{op1[63:32], op2[63:32]};
    end

    // Operand unpack and special-case classification
    logic          sa, sb, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_small;
    logic [EW-1:0] ea, eb;
    logic [FW-1:0] fa, fb;
    logic [MW-1:0] ma, mb;
    logic [XW-1:0] exp_base, exp_load;

    always_comb begin
        sa       = a_q[W-1];
        sb       = b_q[W-1];
        ea       = a_q[W-2 -: EW];
        eb       = b_q[W-2 -: EW];
        fa       = a_q[FW-1:0];
        fb       = b_q[FW-1:0];
        a_zero   = (ea == '0);
        b_zero   = (eb == '0);
        a_inf    = (ea == E_MAX) && (fa == '0);
        b_inf    = (eb == E_MAX) && (fb == '0);
        a_nan    = (ea == E_MAX) && (fa != '0);
        b_nan    = (eb == E_MAX) && (fb != '0);
        ma       = {1'b1, fa};
        mb       = {1'b1, fb};
        a_small  = (ma < mb);
        exp_base = {2'b00, ea} - {2'b00, eb} + BIAS_V;
        exp_load = a_small ? exp_base - XW'(1) : exp_base;
    end

    // One restoring step
    logic [MW+1:0] trial;
    logic          q_bit;
    logic [MW:0]   rem_keep, rem_shift;

    always_comb begin
        trial     = {1'b0, rem_q} - {2'b00, div_q};
        q_bit     = ~trial[MW+1];
        rem_keep  = q_bit ? trial[MW:0] : rem_q;
        rem_shift = {rem_keep[MW-1:0], 1'b0};
    end

    // Rounding: quotient holds mantissa, guard, round; leftover remainder is sticky
    logic          round_up, carry, ovf, unf;
    logic [MW:0]   mant_r;
    logic [MW-1:0] norm;
    logic [XW-1:0] exp_r;

    always_comb begin
        round_up = quo_q[1] & (quo_q[0] | (|rem_q) | quo_q[2]);
        mant_r   = {1'b0, quo_q[Q-1:2]} + (MW + 1)'(round_up);
        carry    = mant_r[MW];
        norm     = carry ? mant_r[MW:1] : mant_r[MW-1:0];
        exp_r    = exp_q + XW'(carry);
        ovf      = $signed(exp_r) >= $signed(EXP_INF);
        unf      = $signed(exp_r) <= $signed(XW'(0));
    end

    logic unused_bits;
    assign unused_bits = ^{norm[MW-1], rem_keep[MW]};

    always_ff @(posedge clock) begin
        if (!rst) begin
            state_q <= StIdle;
            busy    <= 1'b0;
            valid   <= 1'b0;
            result  <= '0;
            flags   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sign_q  <= 1'b0;
            exp_q   <= '0;
            div_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            flg_q   <= '0;
        end else begin
            valid <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        a_q     <= op1[W-1:0];
                        b_q     <= op2[W-1:0];
                        busy    <= 1'b1;
                        state_q <= StLoad;
                    end
                end
                StLoad: begin
                    sign_q  <= sa ^ sb;
                    flg_q   <= '0;
                    state_q <= StDone;
                    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
                        res_q <= pack(1'b0, E_MAX, QNAN_FRAC);
                        flg_q <= 4'b1000;
                    end else if (b_zero && !a_inf) begin
                        res_q <= pack(sa ^ sb, E_MAX, '0);
                        flg_q <= 4'b0100;
                    end else if (a_inf) begin
                        res_q <= pack(sa ^ sb, E_MAX, '0);
                    end else if (a_zero || b_inf) begin
                        res_q <= pack(sa ^ sb, '0, '0);
                    end else begin
                        // Pre-shift a smaller dividend so the quotient lands in [1,2)
                        exp_q   <= exp_load;
                        div_q   <= mb;
                        rem_q   <= a_small ? {ma, 1'b0} : {1'b0, ma};
                        quo_q   <= '0;
                        cnt_q   <= CW'(Q - 1);
                        state_q <= StDiv;
                    end
                end
                StDiv: begin
                    rem_q <= rem_shift;
                    quo_q <= {quo_q[Q-2:0], q_bit};
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        state_q <= StRnd;
                    end
                end
                StRnd: begin
                    state_q <= StDone;
                    if (ovf) begin
                        res_q <= pack(sign_q, E_MAX, '0);
                        flg_q <= 4'b0010;
                    end else if (unf) begin
                        res_q <= pack(sign_q, '0, '0);
                        flg_q <= 4'b0001;
                    end else begin
                        res_q <= pack(sign_q, exp_r[EW-1:0], norm[FW-1:0]);
                        flg_q <= 4'b0000;
                    end
                end
                StDone: begin
                    valid   <= 1'b1;
                    busy    <= 1'b0;
                    result  <= res_q;
                    flags   <= flg_q;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_real_div.sv
// Scoreboard bench for real_div: single- and double-precision instances, directed vectors.
module tb_real_div;

    logic        clock = 1'b0;
    logic        rst   = 1'b0;
    logic        start_s = 1'b0, start_d = 1'b0;
    logic [63:0] op1_s = '0, op2_s = '0, op1_d = '0, op2_d = '0;
    logic        busy_s, valid_s, busy_d, valid_d;
    logic [63:0] result_s, result_d;
    logic [3:0]  flags_s, flags_d;

    real_div #(.IS_DOUBLE(0)) u_sp (
        .clock(clock), .rst(rst), .start(start_s), .op1(op1_s), .op2(op2_s),
        .busy(busy_s), .valid(valid_s), .result(result_s), .flags(flags_s)
    );

    real_div #(.IS_DOUBLE(1)) u_dp (
        .clock(clock), .rst(rst), .start(start_d), .op1(op1_d), .op2(op2_d),
        .busy(busy_d), .valid(valid_d), .result(result_d), .flags(flags_d)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] res;
        logic [3:0]  flg;
        int          lat;
        int          t0;
        string       name;
    } exp_t;

    exp_t q_sp[$];
    exp_t q_dp[$];
    exp_t e_sp, e_dp;
    int   bc_sp = 0, bc_dp = 0;
    int   tests = 0, fails = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic score(input exp_t e, input logic [63:0] r, input logic [3:0] f,
                         input logic b, input int lat, input int bc);
        check({e.name, "_result"}, r, e.res);
        check({e.name, "_flags"}, 64'(f), 64'(e.flg));
        check({e.name, "_latency"}, 64'(lat), 64'(e.lat));
        check({e.name, "_busy_cycles"}, 64'(bc), 64'(e.lat - 1));
        check({e.name, "_busy_low_at_valid"}, 64'(b), 64'(0));
    endtask

    // Monitors: pop and compare whenever a DUT presents valid
    always @(negedge clock) begin
        if (rst) begin
            if (q_sp.size() != 0 && busy_s && cyc > q_sp[0].t0) bc_sp++;
            if (valid_s) begin
                if (q_sp.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL sp_unexpected_valid: got valid=1 result %h expected no valid",
                             result_s);
                end else begin
                    e_sp = q_sp.pop_front();
                    score(e_sp, result_s, flags_s, busy_s, cyc - e_sp.t0, bc_sp);
                    bc_sp = 0;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (rst) begin
            if (q_dp.size() != 0 && busy_d && cyc > q_dp[0].t0) bc_dp++;
            if (valid_d) begin
                if (q_dp.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL dp_unexpected_valid: got valid=1 result %h expected no valid",
                             result_d);
                end else begin
                    e_dp = q_dp.pop_front();
                    score(e_dp, result_d, flags_d, busy_d, cyc - e_dp.t0, bc_dp);
                    bc_dp = 0;
                end
            end
        end
    end

    // Called at a negedge; start is sampled on the following posedge
    task automatic issue(input bit dbl, input string name, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] res, input logic [3:0] flg,
                         input int lat);
        exp_t e;
        e.res  = res;
        e.flg  = flg;
        e.lat  = lat;
        e.t0   = cyc + 1;
        e.name = name;
        if (dbl) begin
            op1_d = a; op2_d = b; start_d = 1'b1;
            q_dp.push_back(e);
        end else begin
            op1_s = a; op2_s = b; start_s = 1'b1;
            q_sp.push_back(e);
        end
        @(negedge clock);
        start_s = 1'b0;
        start_d = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int bound);
        bit done;
        done = 1'b0;
        for (int i = 0; i < bound && !done; i++) begin
            if (q_sp.size() == 0 && q_dp.size() == 0) done = 1'b1;
            else @(negedge clock);
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: got no valid within %0d cycles expected valid", name, bound);
            q_sp.delete();
            q_dp.delete();
        end
    endtask

    initial begin
        repeat (3) @(negedge clock);
        check("reset_busy_sp", 64'(busy_s), 64'(0));
        check("reset_valid_sp", 64'(valid_s), 64'(0));
        check("reset_result_sp", result_s, 64'h0);
        check("reset_flags_sp", 64'(flags_s), 64'(0));
        check("reset_busy_dp", 64'(busy_d), 64'(0));
        check("reset_result_dp", result_d, 64'h0);
        rst = 1'b1;
        @(negedge clock);

        issue(0, "sp_6_div_2", 64'h40C00000, 64'h40000000, 64'h40400000, 4'b0000, 29);
        wait_idle("sp_6_div_2", 100);
        issue(0, "sp_1_div_3", 64'h3F800000, 64'h40400000, 64'h3EAAAAAB, 4'b0000, 29);
        wait_idle("sp_1_div_3", 100);
        issue(0, "sp_m1_div_3", 64'hBF800000, 64'h40400000, 64'hBEAAAAAB, 4'b0000, 29);
        wait_idle("sp_m1_div_3", 100);
        issue(0, "sp_1_div_0", 64'h3F800000, 64'h00000000, 64'h7F800000, 4'b0100, 2);
        wait_idle("sp_1_div_0", 100);
        issue(0, "sp_0_div_0", 64'h00000000, 64'h00000000, 64'h7FC00000, 4'b1000, 2);
        wait_idle("sp_0_div_0", 100);
        issue(0, "sp_m0_div_5", 64'h80000000, 64'h40A00000, 64'h80000000, 4'b0000, 2);
        wait_idle("sp_m0_div_5", 100);
        issue(0, "sp_1_div_inf", 64'h3F800000, 64'h7F800000, 64'h00000000, 4'b0000, 2);
        wait_idle("sp_1_div_inf", 100);
        issue(0, "sp_overflow", 64'h7F7FFFFF, 64'h3F000000, 64'h7F800000, 4'b0010, 29);
        wait_idle("sp_overflow", 100);
        issue(0, "sp_underflow", 64'h00800000, 64'h40000000, 64'h00000000, 4'b0001, 29);
        wait_idle("sp_underflow", 100);

        // Starts during a running division must be ignored
        issue(0, "sp_ignored_start", 64'h40C00000, 64'h40000000, 64'h40400000, 4'b0000, 29);
        repeat (3) @(negedge clock);
        op1_s = 64'h3F800000; op2_s = 64'h40400000; start_s = 1'b1;
        @(negedge clock);
        start_s = 1'b0;
        repeat (4) @(negedge clock);
        start_s = 1'b1;
        @(negedge clock);
        start_s = 1'b0;
        wait_idle("sp_ignored_start", 100);
        repeat (40) @(negedge clock);
        check("sp_ignored_start_hold", result_s, 64'h40400000);

        // Reset mid-division discards the operation
        issue(0, "sp_reset_victim", 64'h40C00000, 64'h40000000, 64'h40400000, 4'b0000, 29);
        repeat (8) @(negedge clock);
        rst = 1'b0;
        @(negedge clock);
        rst = 1'b1;
        q_sp.delete();
        bc_sp = 0;
        check("midreset_busy", 64'(busy_s), 64'(0));
        check("midreset_valid", 64'(valid_s), 64'(0));
        check("midreset_result", result_s, 64'h0);
        check("midreset_flags", 64'(flags_s), 64'(0));
        repeat (40) @(negedge clock);
        issue(0, "sp_after_reset", 64'h3F800000, 64'h40400000, 64'h3EAAAAAB, 4'b0000, 29);
        wait_idle("sp_after_reset", 100);

        issue(1, "dp_1_div_2", 64'h3FF0000000000000, 64'h4000000000000000,
              64'h3FE0000000000000, 4'b0000, 58);
        wait_idle("dp_1_div_2", 150);
        issue(1, "dp_1_div_3", 64'h3FF0000000000000, 64'h4008000000000000,
              64'h3FD5555555555555, 4'b0000, 58);
        wait_idle("dp_1_div_3", 150);
        repeat (5) @(negedge clock);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
